// File: rtl/nes_pad_reader_pkg.sv
// Shared constants for the NES/SNES pad poller: FSM state codes and button bit positions.
package nes_pad_reader_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LATCH = 3'd1;
   localparam logic [2:0] ST_LOW   = 3'd2;
   localparam logic [2:0] ST_HIGH  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   // Bit positions in the buttons/pressed bytes, in pad shift-out order.
   localparam int BTN_A      = 0;
   localparam int BTN_B      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/nes_pad_reader_sync2.sv
// Two-flop synchroniser for an asynchronous input; resets to 1 (idle level of active-low pad lines).
module nes_pad_reader_sync2 (
   input  logic clk,
   input  logic rstb,
   input  logic d,
   output logic q
);

   logic meta_p0;
   logic sync_p1;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         meta_p0 <= 1'b1;
         sync_p1 <= 1'b1;
      end else begin
         meta_p0 <= d;
         sync_p1 <= meta_p0;
      end
   end

   assign q = sync_p1;

endmodule

// File: rtl/nes_pad_reader.sv
// NES/SNES pad poller: drives latch/clock, shifts in the button byte and keeps a sticky pressed mask.
module nes_pad_reader
   import nes_pad_reader_pkg::*;
#(
   parameter int unsigned CLK_DIV     = 120,
   parameter int unsigned POLL_PERIOD = 333333,
   parameter int unsigned N_BITS      = 8
) (
   input  logic              clk,
   input  logic              rstb,
   input  logic              start,
   input  logic              auto_en,
   input  logic              clr_pressed,
   input  logic              NES_data,
   output logic              NES_clk,
   output logic              NES_latch,
   output logic [N_BITS-1:0] buttons,
   output logic [N_BITS-1:0] pressed,
   output logic              valid,
   output logic              busy,
   output logic              irq
);

   localparam int PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BI_W  = (N_BITS > 1) ? $clog2(N_BITS) : 1;
   localparam int CNT_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLK_DIV - 1);
   localparam logic [BI_W-1:0]  BIT_LAST = BI_W'(N_BITS - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_PERIOD - 1);

   logic              sdata;
   logic [2:0]        state;
   logic [2:0]        state_nxt;
   logic [PH_W-1:0]   phase;
   logic              phase_last;
   logic              latch_half;
   logic [BI_W-1:0]   bit_idx;
   logic [N_BITS-1:0] shreg;
   logic [CNT_W-1:0]  cnt;
   logic              tick;
   logic              trig;

   nes_pad_reader_sync2 u_sync2 (
      .clk  (clk),
      .rstb (rstb),
      .d    (NES_data),
      .q    (sdata)
   );

   always_comb begin
      tick       = auto_en && (cnt == CNT_LAST);
      phase_last = (phase == PH_LAST);
      trig       = (start || tick) && (state == ST_IDLE);
      state_nxt  = state;
      case (state)
         ST_IDLE:  if (trig) state_nxt = ST_LATCH;
         ST_LATCH: if (phase_last && latch_half) state_nxt = ST_LOW;
         ST_LOW:   if (phase_last) state_nxt = (bit_idx == BIT_LAST) ? ST_DONE : ST_HIGH;
         ST_HIGH:  if (phase_last) state_nxt = ST_LOW;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Poll timer: triggers that land while busy are simply lost, the count keeps wrapping.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         cnt <= '0;
      end else if (!auto_en || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state      <= ST_IDLE;
         phase      <= '0;
         latch_half <= 1'b0;
         bit_idx    <= '0;
         shreg      <= '0;
         NES_latch  <= 1'b0;
         NES_clk    <= 1'b0;
      end else begin
         state <= state_nxt;
         if ((state == ST_IDLE) || (state_nxt != state) || phase_last) begin
            phase <= '0;
         end else begin
            phase <= phase + 1'b1;
         end
         // LATCH spans two phase periods; latch_half marks the second one.
         latch_half <= (state == ST_LATCH) && (latch_half || phase_last);
         if (trig) begin
            bit_idx <= '0;
            shreg   <= '0;
         end else if ((state == ST_HIGH) && phase_last) begin
            bit_idx <= bit_idx + 1'b1;
         end
         if ((state == ST_LOW) && phase_last) begin
            shreg[bit_idx] <= ~sdata;
         end
         // Pins are registered from the next state so they never glitch on decode.
         NES_latch <= (state_nxt == ST_LATCH);
         NES_clk   <= (state_nxt == ST_HIGH);
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         buttons <= '0;
         pressed <= '0;
         valid   <= 1'b0;
      end else if (state == ST_DONE) begin
         buttons <= shreg;
         pressed <= (pressed & ~{N_BITS{clr_pressed}}) | (shreg & ~buttons);
         valid   <= 1'b1;
      end else begin
         valid <= 1'b0;
         if (clr_pressed) begin
            pressed <= '0;
         end
      end
   end

   assign busy = (state != ST_IDLE);
   assign irq  = |pressed;

endmodule

// File: tb/tb_nes_pad_reader.sv
// Directed bench for nes_pad_reader with a 4021-style pad model on the serial pins.
module tb_nes_pad_reader;
   import nes_pad_reader_pkg::*;

   localparam int CLK_DIV     = 4;
   localparam int POLL_PERIOD = 200;
   localparam int N_BITS      = 8;
   localparam int LAT         = 17 * CLK_DIV + 1;

   localparam logic [7:0] M_A  = 8'(1 << BTN_A);
   localparam logic [7:0] M_SR = 8'((1 << BTN_START) | (1 << BTN_RIGHT));
   localparam logic [7:0] M_OTHER = 8'((1 << BTN_B) | (1 << BTN_SELECT) | (1 << BTN_UP) |
                                       (1 << BTN_DOWN) | (1 << BTN_LEFT));

   logic clk = 1'b0;
   logic rstb = 1'b0;
   logic start = 1'b0;
   logic auto_en = 1'b0;
   logic clr_pressed = 1'b0;
   logic NES_data;
   logic NES_clk;
   logic NES_latch;
   logic [N_BITS-1:0] buttons;
   logic [N_BITS-1:0] pressed;
   logic valid;
   logic busy;
   logic irq;

   nes_pad_reader #(
      .CLK_DIV     (CLK_DIV),
      .POLL_PERIOD (POLL_PERIOD),
      .N_BITS      (N_BITS)
   ) dut (
      .clk         (clk),
      .rstb        (rstb),
      .start       (start),
      .auto_en     (auto_en),
      .clr_pressed (clr_pressed),
      .NES_data    (NES_data),
      .NES_clk     (NES_clk),
      .NES_latch   (NES_latch),
      .buttons     (buttons),
      .pressed     (pressed),
      .valid       (valid),
      .busy        (busy),
      .irq         (irq)
   );

   always #5 clk = ~clk;

   // Pad model: parallel load while latched, shift toward bit 0 on each clock rise.
   logic [7:0] pad_wire = 8'hFF;
   logic [7:0] pad_sr = 8'hFF;
   always @(posedge NES_clk or posedge NES_latch) begin
      if (NES_latch) pad_sr <= pad_wire;
      else           pad_sr <= {1'b1, pad_sr[7:1]};
   end
   assign NES_data = pad_sr[0];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_latch = 0, n_clkhi = 0, n_busy = 0, n_valid = 0, n_pulse = 0;
   int vcyc [16];
   always @(negedge clk) begin
      if (NES_latch) n_latch <= n_latch + 1;
      if (NES_clk)   n_clkhi <= n_clkhi + 1;
      if (busy)      n_busy  <= n_busy + 1;
      if (valid) begin
         vcyc[n_valid % 16] <= cyc;
         n_valid <= n_valid + 1;
      end
   end
   always @(posedge NES_clk) n_pulse <= n_pulse + 1;

   int n_vec = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic poll(input string tag, input logic [7:0] wire_v, input bit clr_done,
                       input logic [7:0] exp_btn, input logic [7:0] exp_prs);
      int t0, s_latch, s_clkhi, s_busy, s_valid, s_pulse;
      pad_wire = wire_v;
      s_latch = n_latch; s_clkhi = n_clkhi; s_busy = n_busy;
      s_valid = n_valid; s_pulse = n_pulse;
      t0 = cyc + 1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (74) begin
         @(negedge clk);
         clr_pressed = clr_done && (cyc == t0 + LAT - 1);
      end
      clr_pressed = 1'b0;
      check_eq({tag, " valid_count"}, n_valid - s_valid, 1);
      check_eq({tag, " valid_edge"}, vcyc[(n_valid - 1) % 16], t0 + LAT);
      check_eq({tag, " latch_cycles"}, n_latch - s_latch, 2 * CLK_DIV);
      check_eq({tag, " clk_pulses"}, n_pulse - s_pulse, N_BITS - 1);
      check_eq({tag, " clk_high_cycles"}, n_clkhi - s_clkhi, (N_BITS - 1) * CLK_DIV);
      check_eq({tag, " busy_cycles"}, n_busy - s_busy, LAT);
      check_eq({tag, " buttons"}, buttons, exp_btn);
      check_eq({tag, " pressed"}, pressed, exp_prs);
      check_eq({tag, " irq"}, irq, |exp_prs);
   endtask

   initial begin
      int e0, sv, sp;
      repeat (3) @(negedge clk);
      check_eq("rst NES_clk", NES_clk, 0);
      check_eq("rst NES_latch", NES_latch, 0);
      check_eq("rst buttons", buttons, 0);
      check_eq("rst pressed", pressed, 0);
      check_eq("rst valid", valid, 0);
      check_eq("rst busy", busy, 0);
      check_eq("rst irq", irq, 0);
      rstb = 1'b1;
      repeat (2) @(negedge clk);

      // A pressed, then the same again (no new edge), then a plain clear.
      poll("p1", 8'hFE, 1'b0, M_A, M_A);
      poll("p2", 8'hFE, 1'b0, M_A, M_A);
      clr_pressed = 1'b1;
      @(negedge clk);
      clr_pressed = 1'b0;
      @(negedge clk);
      check_eq("clr pressed", pressed, 0);
      check_eq("clr irq", irq, 0);

      // Clear coinciding with DONE: fresh edges survive, older bits go.
      poll("p3", 8'h77, 1'b1, M_SR, M_SR);
      check_eq("p3 other_bits", buttons & M_OTHER, 0);
      poll("p4", 8'hFE, 1'b0, M_A, M_SR | M_A);
      poll("p5", 8'hFE, 1'b1, M_A, 8'h00);
      poll("p6", 8'h77, 1'b0, M_SR, M_SR);

      // Retrigger by start and by the auto tick while busy must be dropped.
      sv = n_valid; sp = n_pulse;
      e0 = cyc + 1;
      auto_en = 1'b1;
      repeat (300) begin
         @(negedge clk);
         start = (cyc == e0 + 149) || (cyc == e0 + 179);
      end
      start = 1'b0;
      auto_en = 1'b0;
      repeat (20) @(negedge clk);
      check_eq("busy_drop valid_count", n_valid - sv, 1);
      check_eq("busy_drop valid_edge", vcyc[(n_valid - 1) % 16], e0 + 150 + LAT);
      check_eq("busy_drop clk_pulses", n_pulse - sp, N_BITS - 1);
      check_eq("busy_drop buttons", buttons, M_SR);

      // Periodic polling, with a start coinciding with the first tick.
      sv = n_valid; sp = n_pulse;
      e0 = cyc + 1;
      auto_en = 1'b1;
      repeat (1000) begin
         @(negedge clk);
         start = (cyc == e0 + POLL_PERIOD - 2);
      end
      start = 1'b0;
      auto_en = 1'b0;
      repeat (100) @(negedge clk);
      check_eq("auto valid_count", n_valid - sv, 5);
      check_eq("auto clk_pulses", n_pulse - sp, 5 * (N_BITS - 1));
      for (int i = 0; i < 5; i++) begin
         check_eq($sformatf("auto valid_edge%0d", i), vcyc[(sv + i) % 16],
                  e0 + POLL_PERIOD - 1 + LAT + POLL_PERIOD * i);
      end
      check_eq("auto pressed", pressed, M_SR);

      // Reset in the middle of the first HIGH phase.
      pad_wire = 8'hFE;
      e0 = cyc + 1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (cyc < e0 + 2 * CLK_DIV + CLK_DIV + 1) @(negedge clk);
      check_eq("midpoll NES_clk", NES_clk, 1);
      check_eq("midpoll busy", busy, 1);
      sv = n_valid;
      rstb = 1'b0;
      #1;
      check_eq("arst NES_clk", NES_clk, 0);
      check_eq("arst NES_latch", NES_latch, 0);
      check_eq("arst buttons", buttons, 0);
      check_eq("arst pressed", pressed, 0);
      check_eq("arst busy", busy, 0);
      check_eq("arst irq", irq, 0);
      repeat (3) @(negedge clk);
      rstb = 1'b1;
      repeat (100) @(negedge clk);
      check_eq("arst no_valid", n_valid - sv, 0);
      check_eq("arst buttons_after", buttons, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
